// File: rtl/ptd_capture_fifo_if.sv
// Capture FIFO port bundle: strobe/data toward the capture stage, valid/ready toward the consumer.
// The master modport is the capture FIFO itself; the slave modport is the surrounding logic.
interface ptd_capture_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic                       strobe;
    logic [WIDTH-1:0]           d;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_data;
    logic [$clog2(DEPTH):0]     count;
    logic                       overflow;

    modport master (
        input  strobe,
        input  d,
        input  out_ready,
        output out_valid,
        output out_data,
        output count,
        output overflow
    );

    modport slave (
        output strobe,
        output d,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  count,
        input  overflow
    );
endinterface

// File: rtl/ptd_capture_fifo.sv
// Edge-triggered capture of d on strobe rises into a small FIFO with valid/ready output.
// Define PTD_CAPTURE_BOTHEDGE_EN to capture on both strobe edges instead of rising only.
module ptd_capture_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    ptd_capture_fifo_if.master  bus
);
    localparam int aw = $clog2(DEPTH);
    localparam int cw = aw + 1;
    localparam logic [cw-1:0] full_count = cw'(DEPTH);

    logic             strobe_q_reg;
    logic [aw-1:0]    wp_reg;
    logic [aw-1:0]    rp_reg;
    logic [cw-1:0]    count_reg;
    logic [cw-1:0]    count_next;
    logic             overflow_reg;
    logic [WIDTH-1:0] mem [DEPTH];

    logic push;
    logic pop;
    logic full;
    logic not_empty;
    logic wr_en;
    logic drop;

`ifdef PTD_CAPTURE_BOTHEDGE_EN
    assign push = bus.strobe ^ strobe_q_reg;
`else
    assign push = bus.strobe & ~strobe_q_reg;
`endif

    assign not_empty = (count_reg != '0);
    assign full      = (count_reg == full_count);
    assign pop       = not_empty & bus.out_ready;
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;

    always_comb begin
        count_next = count_reg;
        case ({wr_en, pop})
            2'b10:   count_next = count_reg + cw'(1);
            2'b01:   count_next = count_reg - cw'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q_reg <= 1'b0;
            wp_reg       <= '0;
            rp_reg       <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            strobe_q_reg <= bus.strobe;
            count_reg    <= count_next;
            overflow_reg <= overflow_reg | drop;
            if (wr_en) begin
                wp_reg <= wp_reg + aw'(1);
            end
            if (pop) begin
                rp_reg <= rp_reg + aw'(1);
            end
        end
    end

    // Storage is deliberately left out of reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp_reg] <= bus.d;
        end
    end

    assign bus.out_data  = mem[rp_reg];
    assign bus.out_valid = not_empty;
    assign bus.count     = count_reg;
    assign bus.overflow  = overflow_reg;
endmodule

// File: doc/ptd_capture_fifo.md
# ptd_capture_fifo

Synchronous edge-triggered capture stage that sits directly downstream of the clock pulse-transition detector. It samples a 32-bit data word on each detected rising edge of the strobe and buffers captured words in a small FIFO. A valid/ready interface presents them to the consuming stage, so a slow consumer no longer loses values the way a bare level-enabled register does.

## Interface
- `WIDTH`, default 32: data word width in bits.
- `DEPTH`, default 4: FIFO entries; power of two, minimum 2.
- `clk` input, 1: single clock; all state updates on its rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `strobe` input, 1: capture strobe (the pulse-detector output); level sampled on `clk`.
- `d` input, `WIDTH`: data captured when a strobe edge is detected.
- `out_valid` output, 1: head entry is present on `out_data`.
- `out_ready` input, 1: consumer accepts the head entry when high together with `out_valid`.
- `out_data` output, `WIDTH`: head-of-FIFO word.
- `count` output, $clog2(`DEPTH`)+1: number of stored entries.
- `overflow` output, 1: sticky; set when a capture is dropped because the FIFO was full.

## Operation
- Edge detect:
  - `strobe_q` is `strobe` registered on `clk`.
  - `rise = strobe & ~strobe_q`, computed combinationally.
  - A capture request (`push`) equals `rise`; in the both-edge build it equals `strobe ^ strobe_q` (see Configuration).
- Pop: `pop = out_valid & out_ready`.
- Storage: `DEPTH`-entry memory with write pointer `wp` and read pointer `rp`, each $clog2(`DEPTH`) bits.
  - Pointers wrap modulo `DEPTH` by natural overflow.
  - `out_data = mem[rp]`, a combinational read. Its value is don't-care when `out_valid = 0`.
- Push handling:
  - When `push` and (`count < DEPTH` or `pop`): write `d` to `mem[wp]` and increment `wp`.
  - When `push`, `count == DEPTH` and not `pop`: drop the word and set `overflow` to 1.
- Pop handling: on `pop`, increment `rp`.
- Count update: +1 on push only, −1 on pop only, unchanged when both or neither.
- Flags: `out_valid = (count != 0)`; full condition is `count == DEPTH`.
- `overflow` clears only on reset.
- No empty bypass: a word captured into an empty FIFO is not visible until the following cycle.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `strobe_q` = 0, `wp` = `rp` = 0, `count` = 0.
  - `out_valid` = 0, `overflow` = 0.
  - Memory contents are not reset.
- Reset released with `strobe` already high: the first rising `clk` edge sees `strobe_q` = 0, so this counts as a rising edge and captures `d`.
- Capture latency:
  - `strobe` goes high before edge N, so `d` is sampled at edge N.
  - `out_valid` = 1 and `out_data` = that word after edge N, provided the FIFO was empty.
- A strobe held high for many cycles produces exactly one capture.
- Strobe toggling:
  - A strobe pulse shorter than one `clk` period that does not straddle a rising edge is not seen. This is a requirement on the upstream detector.
  - Back-to-back strobe rises are at least 2 cycles apart by construction.
- Pop takes effect at the edge where `out_valid & out_ready`; the next entry appears after that edge.
- Simultaneous push and pop:
  - When full: the push is accepted, `count` stays `DEPTH`, and `overflow` is not set.
  - When empty: pop cannot occur, because `out_valid` = 0.
- Reset asserted mid-operation discards all entries immediately; `out_valid` falls asynchronously.

## Configuration
- `PTD_CAPTURE_BOTHEDGE_EN`:
  - Defined: `push = strobe ^ strobe_q`, so both the rising and falling strobe edges capture `d`.
  - Undefined (default): only rising edges capture.
- All other behaviour is identical in both builds.

## Test plan
- Reset with `strobe`=0, then raise `strobe` for 1 cycle with `d`=0x3 → after that edge `out_valid`=1, `out_data`=0x3, `count`=1. With `out_ready`=1 one cycle later → `count`=0, `out_valid`=0.
- `out_ready`=0; 4 strobe rises with `d`=4,5,6,7 → `count`=4, `overflow`=0. A 5th rise with `d`=8 → `overflow`=1, `count`=4. Then drain with `out_ready`=1 → reads 4,5,6,7 in order; `overflow` stays 1.
- FIFO full (1..4) and `out_ready`=1, with a strobe rise on the same edge carrying `d`=9 → `count`=4, `overflow`=0. Drain → 2,3,4,9.
- Hold `strobe`=1 for 10 cycles while `d` increments → exactly one entry, holding `d` from the first edge. In the `PTD_CAPTURE_BOTHEDGE_EN` build, the falling edge adds a second entry.
- `strobe`=1 during reset, then release with `d`=0xA → one capture of 0xA on the first edge.
- Load 3 entries, assert `rst_n`=0 between clock edges → `out_valid`=0 and `count`=0 immediately. After release, the FIFO is empty and `wp`=`rp`=0; the next capture appears at `out_data`.
